// File: rtl/draw_pkg.sv
// Shared types and constants for the raster draw engine.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SPRITE_W = 40;
    localparam int SPRITE_H = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic {
        MODE_SCREEN = 1'b0,
        MODE_SPRITE = 1'b1
    } mode_t;

    // True when the widened coordinate sums land inside the visible screen.
    function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys);
        return (xs < 9'(SCREEN_W)) && (ys < 8'(SCREEN_H));
    endfunction

endpackage

// File: rtl/draw_engine_if.sv
// Controller/ROM/VGA-facing signal bundle of the draw engine.
interface draw_engine_if #(
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15
);
    logic               start;
    logic               mode;
    logic [7:0]         xInit;
    logic [6:0]         yInit;
    logic [4:0]         memorySel;
    logic               black;
    logic [COLOR_W-1:0] romColor;
    logic [ADDR_W-1:0]  romAddr;
    logic [4:0]         romSel;
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] colour;
    logic               plot;
    logic               busy;
    logic               done;

    // Environment side: controller request, ROM data; observes pixel stream.
    modport master (
        output start, mode, xInit, yInit, memorySel, black, romColor,
        input  romAddr, romSel, x, y, colour, plot, busy, done
    );

    // Engine side.
    modport slave (
        input  start, mode, xInit, yInit, memorySel, black, romColor,
        output romAddr, romSel, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/raster_counter.sv
// Column/row/linear-address walker for one image; the address is a plain
// incrementing counter so no multiplier is needed.
module raster_counter
    import draw_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clr,
    input  logic              adv,
    input  mode_t             mode,
    output logic [7:0]        col,
    output logic [6:0]        row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [7:0]        col_q;
    logic [6:0]        row_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        w_last;
    logic [6:0]        h_last;
    logic              col_end;

    assign w_last  = (mode == MODE_SPRITE) ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
    assign h_last  = (mode == MODE_SPRITE) ? 7'(SPRITE_H - 1) : 7'(SCREEN_H - 1);
    assign col_end = (col_q == w_last);
    assign last    = col_end && (row_q == h_last);

    // Advance one pixel per enabled cycle; wrap everything after the final pixel.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (adv) begin
            if (last) begin
                col_q  <= '0;
                row_q  <= '0;
                addr_q <= '0;
            end else begin
                addr_q <= addr_q + ADDR_W'(1);
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_q + 7'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;

endmodule

// File: rtl/draw_engine.sv
// Raster draw engine: start/done handshake, parameter latches, one-stage
// pixel pipeline aligned with the synchronous colour ROM.
module draw_engine
    import draw_pkg::*;
#(
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15
) (
    input  logic         clk,
    input  logic         stateReset,
    draw_engine_if.slave bus
);

    state_t      state_q;
    mode_t       mode_q;
    logic [7:0]  xinit_q;
    logic [6:0]  yinit_q;
    logic [4:0]  sel_q;
    logic        black_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic        plot_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]         col;
    logic [6:0]         row;
    logic [ADDR_W-1:0]  addr;
    logic               last;
    logic [8:0]         sum_x;
    logic [7:0]         sum_y;
    logic [COLOR_W-1:0] colour_d;

    raster_counter #(.ADDR_W(ADDR_W)) u_raster (
        .clk  (clk),
        .srst (stateReset),
        .clr  (state_q == IDLE),
        .adv  (state_q == RUN),
        .mode (mode_q),
        .col  (col),
        .row  (row),
        .addr (addr),
        .last (last)
    );

    // Widened sums so off-screen pixels can be detected before truncation.
    assign sum_x = {1'b0, xinit_q} + {1'b0, col};
    assign sum_y = {1'b0, yinit_q} + {1'b0, row};

    // Control FSM plus the registered pixel stage feeding the VGA adapter.
    always_ff @(posedge clk) begin
        if (stateReset) begin
            state_q <= IDLE;
            mode_q  <= MODE_SCREEN;
            xinit_q <= '0;
            yinit_q <= '0;
            sel_q   <= '0;
            black_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            plot_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= mode_t'(bus.mode);
                        xinit_q <= bus.xInit;
                        yinit_q <= bus.yInit;
                        sel_q   <= bus.memorySel;
                        black_q <= bus.black;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    x_q    <= sum_x[7:0];
                    y_q    <= sum_y[6:0];
                    plot_q <= on_screen(sum_x, sum_y);
                    if (last) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ROM data arrives alongside the registered coordinates; mask when erasing or idle.
    assign colour_d = (plot_q && !black_q) ? bus.romColor : '0;

    assign bus.romAddr = addr;
    assign bus.romSel  = sel_q;
    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_d;
    assign bus.plot    = plot_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_draw_engine.sv
// Self-checking bench for draw_engine: a scoreboard queue of expected pixels
// is filled at each start and drained by a negedge monitor.
module tb_draw_engine;
    import draw_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic stateReset;
    always #5 clk = ~clk;

    draw_engine_if #(.COLOR_W(3), .ADDR_W(15)) bus ();

    draw_engine #(.COLOR_W(3), .ADDR_W(15)) dut (
        .clk        (clk),
        .stateReset (stateReset),
        .bus        (bus.slave)
    );

    // Colour ROM model: one-cycle latency, data = address low bits.
    always @(posedge clk) bus.romColor <= bus.romAddr[2:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pix_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int prints = 0;
    int start_cyc, plot_count, first_plot_rel, last_plot_rel;
    int done_count, done_rel, busy_count, first_busy_rel, max_x, max_y;
    pix_t first_pix, last_pix;

    // Monitor: scoreboard pops on every plot, plus per-draw statistics.
    initial forever begin
        @(negedge clk);
        if (stateReset !== 1'b1) begin
            int rel;
            pix_t got;
            rel = cyc - start_cyc;
            got = {bus.x, bus.y, bus.colour};
            if (bus.plot !== 1'b1) begin
                checks++;
                if (bus.colour !== 3'd0) begin
                    errors++;
                    if (prints++ < 20) $display("FAIL colour_without_plot: got %0d required 0 (rel cycle %0d)", bus.colour, rel);
                end
            end else begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    if (prints++ < 20) $display("FAIL unexpected_plot: got x=%0d y=%0d, required no plot (rel cycle %0d)", bus.x, bus.y, rel);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        if (prints++ < 20)
                            $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d", bus.x, bus.y, bus.colour, e.x, e.y, e.c);
                    end
                end
                plot_count++;
                if (plot_count == 1) begin
                    first_plot_rel = rel;
                    first_pix = got;
                end
                last_plot_rel = rel;
                last_pix = got;
                if (int'(bus.x) > max_x) max_x = int'(bus.x);
                if (int'(bus.y) > max_y) max_y = int'(bus.y);
            end
            if (bus.busy === 1'b1) begin
                busy_count++;
                if (busy_count == 1) first_busy_rel = rel;
            end
            if (bus.done === 1'b1) begin
                done_count++;
                done_rel = rel;
            end
        end
    end

    task automatic push_expected(input logic md, input logic [7:0] x0, input logic [6:0] y0, input logic blk);
        int w, h, idx;
        pix_t e;
        w = md ? 40 : 160;
        h = md ? 40 : 120;
        idx = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int xs, ys;
                xs = int'(x0) + c;
                ys = int'(y0) + r;
                if (xs < 160 && ys < 120) begin
                    e.x = 8'(xs);
                    e.y = 7'(ys);
                    e.c = blk ? 3'd0 : 3'(idx % 8);
                    exp_q.push_back(e);
                end
                idx++;
            end
        end
    endtask

    // Raises start for the current cycle, then returns at cycle 1 (+1 time unit).
    task automatic start_draw(input logic md, input logic [7:0] x0, input logic [6:0] y0,
                              input logic [4:0] sel, input logic blk);
        bus.start = 1'b1;
        bus.mode = md;
        bus.xInit = x0;
        bus.yInit = y0;
        bus.memorySel = sel;
        bus.black = blk;
        start_cyc = cyc;
        plot_count = 0; first_plot_rel = -1; last_plot_rel = -1;
        done_count = 0; done_rel = -1; busy_count = 0; first_busy_rel = -1;
        max_x = -1; max_y = -1;
        push_expected(md, x0, y0, blk);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Waits for done while scrambling every input; optionally pulses start at one rel cycle.
    task automatic wait_done(input int budget, input int inject_rel);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
            if (done_count != 0) break;
            bus.mode = 1'($urandom);
            bus.xInit = 8'($urandom);
            bus.yInit = 7'($urandom);
            bus.memorySel = 5'($urandom);
            bus.black = 1'($urandom);
            bus.start = ((cyc - start_cyc) == inject_rel);
        end
        bus.start = 1'b0;
        checks++;
        if (done_count == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one", budget);
        end
        $display("draw finished: plots=%0d done_cycle=%0d", plot_count, done_rel);
    endtask

    task automatic test_reset;
        stateReset = 1'b1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.xInit = '0; bus.yInit = '0;
        bus.memorySel = 5'd17; bus.black = 1'b0;
        start_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.romAddr, bus.romSel, bus.x, bus.y, bus.plot, bus.busy, bus.done, bus.colour} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d sel=%0d x=%0d y=%0d plot=%b busy=%b done=%b c=%0d, required all 0",
                     bus.romAddr, bus.romSel, bus.x, bus.y, bus.plot, bus.busy, bus.done, bus.colour);
        end
        stateReset = 1'b0;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_screen;
        @(posedge clk); #1;
        start_draw(1'b0, 8'd0, 7'd0, 5'd9, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.romAddr !== 15'd0) begin
            errors++;
            $display("FAIL screen_cycle1: got busy=%b addr=%0d, required busy=1 addr=0", bus.busy, bus.romAddr);
        end
        checks++;
        if (bus.romSel !== 5'd9) begin
            errors++;
            $display("FAIL screen_romsel: got %0d required 9", bus.romSel);
        end
        wait_done(20000, -1);
        checks++;
        if (done_rel !== 19202) begin errors++; $display("FAIL screen_done_cycle: got %0d required 19202", done_rel); end
        checks++;
        if (plot_count !== 19200) begin errors++; $display("FAIL screen_plot_count: got %0d required 19200", plot_count); end
        checks++;
        if (first_plot_rel !== 2 || first_pix !== {8'd0, 7'd0, 3'd0}) begin
            errors++;
            $display("FAIL screen_first_plot: got cycle %0d pix %h, required cycle 2 x=0 y=0 c=0", first_plot_rel, first_pix);
        end
        checks++;
        if (last_plot_rel !== 19201 || last_pix !== {8'd159, 7'd119, 3'd7}) begin
            errors++;
            $display("FAIL screen_last_plot: got cycle %0d pix %h, required cycle 19201 x=159 y=119 c=7", last_plot_rel, last_pix);
        end
        checks++;
        if (busy_count !== 19201 || first_busy_rel !== 1) begin
            errors++;
            $display("FAIL screen_busy: got %0d cycles from %0d, required 19201 from 1", busy_count, first_busy_rel);
        end
        @(negedge clk); #1;
        checks++;
        if (done_count !== 1) begin errors++; $display("FAIL screen_done_pulses: got %0d required 1", done_count); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL screen_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_sprite;
        @(posedge clk); #1;
        start_draw(1'b1, 8'd60, 7'd40, 5'd3, 1'b0);
        wait_done(2000, -1);
        checks++;
        if (done_rel !== 1602) begin errors++; $display("FAIL sprite_done_cycle: got %0d required 1602", done_rel); end
        checks++;
        if (plot_count !== 1600) begin errors++; $display("FAIL sprite_plot_count: got %0d required 1600", plot_count); end
        checks++;
        if (first_pix !== {8'd60, 7'd40, 3'd0} || last_pix !== {8'd99, 7'd79, 3'd7}) begin
            errors++;
            $display("FAIL sprite_corners: got first %h last %h, required (60,40,0) and (99,79,7)", first_pix, last_pix);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL sprite_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_clip;
        @(posedge clk); #1;
        start_draw(1'b1, 8'd140, 7'd100, 5'd4, 1'b0);
        wait_done(2000, -1);
        checks++;
        if (plot_count !== 400) begin errors++; $display("FAIL clip_plot_count: got %0d required 400", plot_count); end
        checks++;
        if (max_x !== 159 || max_y !== 119) begin
            errors++;
            $display("FAIL clip_extent: got max x=%0d y=%0d, required 159 119", max_x, max_y);
        end
        checks++;
        if (done_rel !== 1602) begin errors++; $display("FAIL clip_done_cycle: got %0d required 1602", done_rel); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL clip_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_black;
        @(posedge clk); #1;
        start_draw(1'b1, 8'd10, 7'd10, 5'd5, 1'b1);
        wait_done(2000, -1);
        checks++;
        if (plot_count !== 1600) begin errors++; $display("FAIL black_plot_count: got %0d required 1600", plot_count); end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL black_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_mid_start;
        @(posedge clk); #1;
        start_draw(1'b1, 8'd0, 7'd0, 5'd6, 1'b0);
        wait_done(2000, 500);
        checks++;
        if (done_rel !== 1602 || plot_count !== 1600) begin
            errors++;
            $display("FAIL mid_start: got done %0d plots %0d, required 1602 and 1600", done_rel, plot_count);
        end
        @(negedge clk); #1;
        checks++;
        if (busy_count !== 1601 || done_count !== 1) begin
            errors++;
            $display("FAIL mid_start_busy: got busy %0d done %0d, required 1601 and 1", busy_count, done_count);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_start_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        @(posedge clk); #1;
        start_draw(1'b1, 8'd5, 7'd5, 5'd7, 1'b0);
        wait_done(2000, -1);
        checks++;
        if (done_rel !== 1602 || plot_count !== 1600) begin
            errors++;
            $display("FAIL b2b_first: got done %0d plots %0d, required 1602 and 1600", done_rel, plot_count);
        end
        // Still inside the done cycle: this start must be accepted.
        start_draw(1'b1, 8'd100, 7'd60, 5'd8, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.romAddr !== 15'd0 || bus.romSel !== 5'd8) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b addr=%0d sel=%0d, required 1 0 8", bus.busy, bus.romAddr, bus.romSel);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.romAddr !== 15'd1) begin errors++; $display("FAIL b2b_addr1: got %0d required 1", bus.romAddr); end
        wait_done(2000, -1);
        checks++;
        if (done_rel !== 1602 || plot_count !== 1600) begin
            errors++;
            $display("FAIL b2b_second: got done %0d plots %0d, required 1602 and 1600", done_rel, plot_count);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_abort;
        int pc;
        @(posedge clk); #1;
        start_draw(1'b0, 8'd0, 7'd0, 5'd11, 1'b0);
        while ((cyc - start_cyc) < 1000) begin
            @(posedge clk); #1;
        end
        stateReset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.romAddr, bus.romSel, bus.x, bus.y, bus.plot, bus.busy, bus.done, bus.colour} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got addr=%0d sel=%0d x=%0d y=%0d plot=%b busy=%b done=%b c=%0d, required all 0",
                     bus.romAddr, bus.romSel, bus.x, bus.y, bus.plot, bus.busy, bus.done, bus.colour);
        end
        stateReset = 1'b0;
        exp_q.delete();
        pc = plot_count;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (done_count !== 0 || plot_count !== pc) begin
            errors++;
            $display("FAIL abort_quiet: got done %0d extra plots %0d, required 0 and 0", done_count, plot_count - pc);
        end
        $display("draw aborted after %0d plots", pc);
        start_draw(1'b1, 8'd20, 7'd20, 5'd12, 1'b0);
        wait_done(2000, -1);
        checks++;
        if (done_rel !== 1602 || plot_count !== 1600) begin
            errors++;
            $display("FAIL abort_recover: got done %0d plots %0d, required 1602 and 1600", done_rel, plot_count);
        end
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL abort_queue: got %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_screen();
        test_sprite();
        test_clip();
        test_black();
        test_mid_start();
        test_back_to_back();
        test_abort();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/draw_engine.md
# draw_engine

Raster draw engine sitting directly downstream of the game controller FSM. On a one-cycle `start` it walks a full 160x120 screen image or a 40x40 sprite, generates the sequential colour-ROM address, and drives pixel coordinates, colour and the `plot` strobe to the VGA adapter. It replaces the controller's per-state xInit/yInit/x/y/address-counter micro-sequencing with a single start/done handshake.

## Interface
Parameters:
- `COLOR_W`, default 3: colour bits per pixel.
- `ADDR_W`, default 15: ROM address width; must cover 19200 words.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `stateReset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  1  0 = screen (160x120), 1 = sprite (40x40).
- `xInit`  in  8  top-left x, 0..159.
- `yInit`  in  7  top-left y, 0..119.
- `memorySel`  in  5  ROM image select.
- `black`  in  1  1 = draw every pixel with colour 0 (erase).
- `romColor`  in  COLOR_W  synchronous ROM read data, 1-cycle latency.
- `romAddr`  out  ADDR_W  ROM word address.
- `romSel`  out  5  latched `memorySel`.
- `x`  out  8  pixel x to VGA.
- `y`  out  7  pixel y to VGA.
- `colour`  out  COLOR_W  pixel colour to VGA.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  draw in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `busy`=0. When `start`=1, latch `mode`, `xInit`, `yInit`, `memorySel`, `black`; clear col, row and address counters; go to RUN.
- RUN: each cycle presents `romAddr` = running index (row*W + col, as an incrementing counter, never a multiplier). col increments 0..W-1; on wrap, row increments. W,H = 160,120 (mode 0) or 40,40 (mode 1). After index N-1 (N = W*H: 19200 or 1600) is issued, go to FLUSH.
- FLUSH: one cycle to drain the ROM pipeline; then back to IDLE with `done`=1 for that one cycle.
- Pipeline stage: each issued address registers x = xInit+col and y = yInit+row (9-/8-bit sums) plus a valid bit; the next cycle drives `x`, `y` and `plot`=valid, with `colour` = `black` ? 0 : `romColor`.
- Clipping: a pixel whose 9-bit x sum is >=160 or 8-bit y sum is >=120 is still addressed but gets `plot`=0. `x`/`y` output the low 8/7 bits.
- `start` in RUN or FLUSH is ignored. No queueing.
- `start` in the same cycle that `done`=1 is accepted; the next draw begins without a gap.
- Latched parameters hold for the whole draw; input changes mid-draw have no effect.
- `stateReset` (any state): state IDLE; all counters 0; `romAddr`, `romSel`, `x`, `y`, `plot`, `busy`, `done` = 0. `colour` = 0 while `plot`=0. An aborted draw produces no `done`.

## Timing
- Cycle 0: `start` sampled in IDLE. Cycle 1: `romAddr`=0, `busy`=1. Cycle 2: first `plot` for pixel 0.
- Pixel k: address in cycle k+1; plot in cycle k+2.
- Screen: plots in cycles 2..19201; `busy` high in 1..19201; `done` in 19202.
- Sprite: plots in cycles 2..1601; `done` in 1602.
- Throughput is 1 pixel/cycle with no stalls. `plot` is never high in IDLE except during the cycle FLUSH drains.

## Structure
- `draw_pkg` holds:
  - constants SCREEN_W=160, SCREEN_H=120, SPRITE_W=40, SPRITE_H=40;
  - the state enum (IDLE, RUN, FLUSH);
  - the mode encoding.
- One sub-module, `raster_counter`: col, row and linear-address counters with W/H select and a `last` flag. FSM, latches and output pipeline stay in `draw_engine`.

## Test plan
- Screen draw, mode 0, (0,0), ROM model returns addr[2:0] -> 19200 plots; first plot x=0,y=0 colour=0 in cycle 2; last plot x=159,y=119 colour=7 (19199 mod 8 = 7); `done` in cycle 19202 only.
- Sprite, mode 1, (60,40) -> first plot (60,40) addr 0; pixel 40 at (60,41); last plot (99,79) addr 1599; 1600 plots total.
- Clipped sprite at (140,100) -> exactly 400 plots, max x=159, max y=119; `done` still in cycle 1602.
- `black`=1 with nonzero ROM data -> every `colour` is 0 on plotted pixels. Toggling `black` mid-draw has no effect.
- `start` pulsed at cycle 500 of a sprite draw -> ignored. A second `start` coincident with `done` -> next draw's `romAddr`=0 appears the following cycle.
- `stateReset` at cycle 1000 of a screen draw -> next cycle all outputs 0, `busy`=0, no `done`. A fresh `start` afterwards completes normally.
